// File: rtl/pdes_pkg.sv
// Shared PDES types: default widths, timestamp type, dispatcher state encoding.
package pdes_pkg;

  localparam int unsigned DEF_DWIDTH = 16;
  localparam int unsigned DEF_HDEPTH = 5;

  typedef logic [DEF_DWIDTH-1:0] ts_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam ts_t TS_MAX = '1;

endpackage

// File: rtl/event_dispatcher_if.sv
// Queue-side and core-side signals of the event dispatcher.
interface event_dispatcher_if #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned HDEPTH    = 5,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned CORE_ID_W = 2
);
  logic [HDEPTH-1:0]    q_count;
  logic [DWIDTH-1:0]    q_out_data;
  logic                 q_enq;
  logic                 q_deq;
  logic [NUM_CORES-1:0] disp_valid;
  logic [DWIDTH-1:0]    disp_data;
  logic [CORE_ID_W-1:0] disp_core;
  logic [NUM_CORES-1:0] disp_ready;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_busy;
  logic [DWIDTH-1:0]    gvt;
  logic                 gvt_valid;

  modport master (
    input  q_count, q_out_data, q_enq, disp_ready, core_done,
    output q_deq, disp_valid, disp_data, disp_core, core_busy, gvt, gvt_valid
  );

  modport slave (
    output q_count, q_out_data, q_enq, disp_ready, core_done,
    input  q_deq, disp_valid, disp_data, disp_core, core_busy, gvt, gvt_valid
  );
endinterface

// File: rtl/rr_select.sv
// Round-robin pick: first set bit of the free mask at or after rr, wrapping.
module rr_select #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned CORE_ID_W = 2
) (
  input  logic [NUM_CORES-1:0] free,
  input  logic [CORE_ID_W-1:0] rr,
  output logic [CORE_ID_W-1:0] sel,
  output logic                 found
);

  logic [CORE_ID_W-1:0] idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = CORE_ID_W'((32'(rr) + k) % NUM_CORES);
      if (!found && free[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/event_dispatcher.sv
// Pops min-timestamp events from prio_q, offers each to one free core round-robin,
// and publishes a registered local GVT over the heap head and in-flight timestamps.
module event_dispatcher
  import pdes_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned HDEPTH    = DEF_HDEPTH,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned CORE_ID_W = 2
) (
  input  logic                CLK,
  input  logic                rst,
  event_dispatcher_if.master  bus
);

  state_t               state;
  logic [DWIDTH-1:0]    hold_data;
  logic [CORE_ID_W-1:0] sel_q;
  logic [CORE_ID_W-1:0] rr;
  logic [CORE_ID_W-1:0] sel_c;
  logic                 found;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] sel_onehot;
  logic [DWIDTH-1:0]    ts [NUM_CORES];
  logic                 q_nonempty;
  logic                 pop_ok;
  logic                 accept;
  logic [DWIDTH-1:0]    gvt_c;
  logic                 gvt_any;
  logic [DWIDTH-1:0]    gvt_q;
  logic                 gvt_valid_q;

  rr_select #(
    .NUM_CORES (NUM_CORES),
    .CORE_ID_W (CORE_ID_W)
  ) u_rr_select (
    .free  (~busy),
    .rr    (rr),
    .sel   (sel_c),
    .found (found)
  );

  assign q_nonempty = (bus.q_count != HDEPTH'(0));
  // Gated by rst so prio_q never loses an event while the dispatcher is held in reset.
  assign pop_ok = !rst && (state == IDLE) && q_nonempty && !bus.q_enq && found;
  assign accept = (state == OFFER) && bus.disp_ready[sel_q];

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
  end

  assign bus.q_deq      = pop_ok;
  assign bus.disp_valid = (state == OFFER) ? sel_onehot : '0;
  assign bus.disp_data  = (state == OFFER) ? hold_data : '0;
  assign bus.disp_core  = (state == OFFER) ? sel_q : '0;
  assign bus.core_busy  = busy;
  assign bus.gvt        = gvt_q;
  assign bus.gvt_valid  = gvt_valid_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      hold_data   <= '0;
      sel_q       <= '0;
      rr          <= '0;
      busy        <= '0;
      gvt_q       <= '1;
      gvt_valid_q <= 1'b0;
    end else begin
      // A new dispatch only targets a free core, so set-after-clear never collides.
      busy        <= (busy & ~bus.core_done) | (accept ? sel_onehot : '0);
      gvt_q       <= gvt_any ? gvt_c : '1;
      gvt_valid_q <= gvt_any;
      unique case (state)
        IDLE: begin
          if (pop_ok) begin
            hold_data <= bus.q_out_data;
            sel_q     <= sel_c;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
            rr    <= (sel_q == CORE_ID_W'(NUM_CORES - 1)) ? '0 : sel_q + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-core timestamps are only read while the matching busy flag is set.
  always_ff @(posedge CLK) begin
    if (accept) begin
      ts[sel_q] <= hold_data;
    end
  end

  always_comb begin
    gvt_any = q_nonempty;
    gvt_c   = q_nonempty ? bus.q_out_data : '1;
    if (state == OFFER) begin
      gvt_any = 1'b1;
      if (hold_data < gvt_c) gvt_c = hold_data;
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (busy[i]) begin
        gvt_any = 1'b1;
        if (ts[i] < gvt_c) gvt_c = ts[i];
      end
    end
  end

endmodule

// File: tb/tb_event_dispatcher.sv
// Self-checking bench for event_dispatcher: a sorted-queue prio_q model feeds the DUT
// and a scoreboard of expected (data, core) dispatches is checked at each handshake.
module tb_event_dispatcher;

  localparam int unsigned DW = 16;
  localparam int unsigned HD = 5;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  event_dispatcher_if #(.DWIDTH(DW), .HDEPTH(HD), .NUM_CORES(NC), .CORE_ID_W(CW)) bus_if ();

  event_dispatcher #(
    .DWIDTH    (DW),
    .HDEPTH    (HD),
    .NUM_CORES (NC),
    .CORE_ID_W (CW)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] core;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] heap[$];
  logic [DW-1:0] enq_data;
  logic [NC-1:0] prev_valid = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pops = 0;
  int n_hs = 0;
  int last_pop = -10;
  int last_hs = -10;

  task automatic heap_refresh();
    bus_if.q_count    = HD'(heap.size());
    bus_if.q_out_data = (heap.size() != 0) ? heap[0] : '0;
  endtask

  task automatic heap_insert(input logic [DW-1:0] v);
    int pos;
    pos = heap.size();
    for (int i = 0; i < heap.size(); i++) begin
      if (v < heap[i]) begin
        pos = i;
        break;
      end
    end
    heap.insert(pos, v);
    heap_refresh();
  endtask

  task automatic expect_disp(input logic [DW-1:0] d, input logic [CW-1:0] c);
    exp_t e;
    e.data = d;
    e.core = c;
    sb.push_back(e);
  endtask

  // One clock: sample combinational outputs, cross the edge, update the prio_q model.
  task automatic tick();
    logic          s_deq;
    logic          s_enq;
    logic [DW-1:0] s_enq_d;
    logic [NC-1:0] s_valid;
    logic [NC-1:0] hs;
    exp_t          e;
    #1;
    s_deq   = bus_if.q_deq;
    s_enq   = bus_if.q_enq;
    s_enq_d = enq_data;
    s_valid = bus_if.disp_valid;
    hs      = s_valid & bus_if.disp_ready;
    checks++;
    if ((s_deq & s_enq) !== 1'b0) begin
      errors++;
      $display("FAIL deq_enq_overlap: q_deq=%b q_enq=%b required q_deq=0", s_deq, s_enq);
    end
    if (s_valid != '0 && prev_valid == '0) begin
      checks++;
      if (last_pop !== cyc - 1) begin
        errors++;
        $display("FAIL offer_latency: last pop cycle=%0d offer cycle=%0d required %0d", last_pop, cyc, cyc - 1);
      end
    end
    if (hs != '0) begin
      n_hs++;
      last_hs = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dispatch: data=%0d core=%0d required no dispatch", bus_if.disp_data, bus_if.disp_core);
      end else begin
        e = sb.pop_front();
        if ({bus_if.disp_data, bus_if.disp_core, s_valid} !== {e.data, e.core, NC'(1) << e.core}) begin
          errors++;
          $display("FAIL dispatch: data=%0d core=%0d valid=%b required data=%0d core=%0d", bus_if.disp_data, bus_if.disp_core, s_valid, e.data, e.core);
        end
      end
    end
    if (s_deq) begin
      n_pops++;
      last_pop = cyc;
    end
    prev_valid = s_valid;
    @(posedge CLK);
    #1;
    if (s_deq && heap.size() != 0) heap.delete(0);
    if (s_enq) heap_insert(s_enq_d);
    bus_if.q_enq     = 1'b0;
    bus_if.core_done = '0;
    heap_refresh();
    cyc++;
    @(negedge CLK);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (n_hs < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n_hs !== target) begin
      errors++;
      $display("FAIL wait_hs: handshakes=%0d required=%0d", n_hs, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus_if.q_deq, bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core} !== {1'b0, 4'b0, 16'h0, 2'b0}) begin
      errors++;
      $display("FAIL reset_disp: deq=%b valid=%b data=%0d core=%0d required all zero", bus_if.q_deq, bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core);
    end
    checks++;
    if ({bus_if.core_busy, bus_if.gvt, bus_if.gvt_valid} !== {4'b0, 16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b gvt=%h gvt_valid=%b required 0000/ffff/0", bus_if.core_busy, bus_if.gvt, bus_if.gvt_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int  base;
    int  prev_hs;
    int  n;
    bit  seen;
    base    = n_hs;
    prev_hs = -1;
    n       = 0;
    seen    = 1'b0;
    bus_if.disp_ready = '1;
    heap_insert(16'd12);
    heap_insert(16'd6);
    heap_insert(16'd97);
    heap_insert(16'd33);
    expect_disp(16'd6, 2'd0);
    expect_disp(16'd12, 2'd1);
    expect_disp(16'd33, 2'd2);
    expect_disp(16'd97, 2'd3);
    while (n_hs < base + 4 && n < 30) begin
      tick();
      n++;
      if (n_hs != base && last_hs == cyc - 1) begin
        if (prev_hs >= 0) begin
          checks++;
          if (last_hs - prev_hs !== 2) begin
            errors++;
            $display("FAIL dispatch_spacing: gap=%0d cycles required 2", last_hs - prev_hs);
          end
        end
        prev_hs = last_hs;
      end
      if (!seen && bus_if.core_busy[0]) begin
        seen = 1'b1;
        checks++;
        if (bus_if.gvt !== 16'd6) begin
          errors++;
          $display("FAIL gvt_first_busy: gvt=%0d required 6", bus_if.gvt);
        end
      end
    end
    checks++;
    if (n_hs !== base + 4) begin
      errors++;
      $display("FAIL basic_count: handshakes=%0d required=%0d", n_hs - base, 4);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_if.q_deq !== 1'b0) begin
        errors++;
        $display("FAIL empty_no_pop: q_deq=%b required 0", bus_if.q_deq);
      end
    end
    checks++;
    if ({bus_if.core_busy, bus_if.gvt, bus_if.gvt_valid} !== {4'b1111, 16'd6, 1'b1}) begin
      errors++;
      $display("FAIL basic_final: busy=%b gvt=%0d valid=%b required 1111/6/1", bus_if.core_busy, bus_if.gvt, bus_if.gvt_valid);
    end
  endtask

  task automatic test_all_busy();
    bus_if.q_enq = 1'b1;
    enq_data     = 16'd51;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus_if.q_deq !== 1'b0) begin
        errors++;
        $display("FAIL all_busy_no_pop: q_deq=%b required 0", bus_if.q_deq);
      end
      tick();
    end
    bus_if.core_done = 4'b0100;
    tick();
    #1;
    checks++;
    if (bus_if.q_deq !== 1'b1) begin
      errors++;
      $display("FAIL pop_after_done: q_deq=%b required 1", bus_if.q_deq);
    end
    expect_disp(16'd51, 2'd2);
    wait_hs(n_hs + 1, 5);
  endtask

  task automatic test_stall();
    int base_pops;
    base_pops         = n_pops;
    bus_if.disp_ready = 4'b1101;
    bus_if.q_enq      = 1'b1;
    enq_data          = 16'd40;
    bus_if.core_done  = 4'b0010;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core, bus_if.q_deq} !== {4'b0010, 16'd40, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: valid=%b data=%0d core=%0d deq=%b required 0010/40/1/0", bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core, bus_if.q_deq);
      end
      tick();
    end
    expect_disp(16'd40, 2'd1);
    bus_if.disp_ready = '1;
    wait_hs(n_hs + 1, 3);
    checks++;
    if (n_pops - base_pops !== 1) begin
      errors++;
      $display("FAIL stall_pops: pops=%0d required 1", n_pops - base_pops);
    end
  endtask

  task automatic test_enq_block();
    int base_pops;
    base_pops = n_pops;
    heap_insert(16'd70);
    heap_insert(16'd80);
    heap_insert(16'd90);
    bus_if.core_done = 4'b0001;
    tick();
    bus_if.q_enq = 1'b1;
    enq_data     = 16'd75;
    #1;
    checks++;
    if (bus_if.q_deq !== 1'b0) begin
      errors++;
      $display("FAIL enq_blocks_pop: q_deq=%b required 0", bus_if.q_deq);
    end
    tick();
    #1;
    checks++;
    if (bus_if.q_deq !== 1'b1) begin
      errors++;
      $display("FAIL pop_after_enq: q_deq=%b required 1", bus_if.q_deq);
    end
    expect_disp(16'd70, 2'd0);
    wait_hs(n_hs + 1, 4);
    checks++;
    if (n_pops - base_pops !== 1) begin
      errors++;
      $display("FAIL enq_block_pops: pops=%0d required 1", n_pops - base_pops);
    end
  endtask

  task automatic test_gvt();
    heap.delete();
    heap_refresh();
    rst = 1'b1;
    bus_if.disp_ready = '1;
    tick();
    rst = 1'b0;
    heap_insert(16'd25);
    heap_insert(16'd28);
    heap_insert(16'd90);
    heap_insert(16'd95);
    expect_disp(16'd25, 2'd0);
    expect_disp(16'd28, 2'd1);
    expect_disp(16'd90, 2'd2);
    expect_disp(16'd95, 2'd3);
    wait_hs(n_hs + 4, 20);
    tick();
    tick();
    checks++;
    if (bus_if.gvt !== 16'd25) begin
      errors++;
      $display("FAIL gvt_inflight: gvt=%0d required 25", bus_if.gvt);
    end
    bus_if.q_enq = 1'b1;
    enq_data     = 16'd21;
    tick();
    tick();
    tick();
    checks++;
    if ({bus_if.gvt, bus_if.gvt_valid} !== {16'd21, 1'b1}) begin
      errors++;
      $display("FAIL gvt_head: gvt=%0d valid=%b required 21/1", bus_if.gvt, bus_if.gvt_valid);
    end
    expect_disp(16'd21, 2'd2);
    bus_if.core_done = 4'b0100;
    tick();
    wait_hs(n_hs + 1, 5);
    bus_if.core_done = 4'b1100;
    tick();
    tick();
    checks++;
    if (bus_if.gvt !== 16'd25) begin
      errors++;
      $display("FAIL gvt_after_drain: gvt=%0d required 25", bus_if.gvt);
    end
    bus_if.core_done = 4'b0001;
    tick();
    tick();
    checks++;
    if ({bus_if.gvt, bus_if.gvt_valid} !== {16'd28, 1'b1}) begin
      errors++;
      $display("FAIL gvt_28: gvt=%0d valid=%b required 28/1", bus_if.gvt, bus_if.gvt_valid);
    end
    bus_if.core_done = 4'b0010;
    tick();
    tick();
    checks++;
    if ({bus_if.gvt, bus_if.gvt_valid} !== {16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL gvt_none: gvt=%h valid=%b required ffff/0", bus_if.gvt, bus_if.gvt_valid);
    end
  endtask

  task automatic test_reset_mid();
    int base_hs;
    bus_if.disp_ready = '1;
    heap_insert(16'd10);
    expect_disp(16'd10, 2'd3);
    wait_hs(n_hs + 1, 5);
    bus_if.disp_ready = '0;
    heap_insert(16'd38);
    tick();
    #1;
    checks++;
    if ({bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core} !== {4'b0001, 16'd38, 2'd0}) begin
      errors++;
      $display("FAIL offer_38: valid=%b data=%0d core=%0d required 0001/38/0", bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core);
    end
    base_hs = n_hs;
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if ({bus_if.q_deq, bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core, bus_if.core_busy, bus_if.gvt, bus_if.gvt_valid}
        !== {1'b0, 4'b0, 16'h0, 2'b0, 4'b0, 16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: deq=%b valid=%b data=%0d core=%0d busy=%b gvt=%h gv=%b required all reset values",
               bus_if.q_deq, bus_if.disp_valid, bus_if.disp_data, bus_if.disp_core, bus_if.core_busy, bus_if.gvt, bus_if.gvt_valid);
    end
    rst = 1'b0;
    bus_if.disp_ready = '1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({n_hs - base_hs, bus_if.core_busy, bus_if.gvt_valid} !== {32'd0, 4'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_discard: dispatches=%0d busy=%b gvt_valid=%b required 0/0000/0", n_hs - base_hs, bus_if.core_busy, bus_if.gvt_valid);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.q_enq      = 1'b0;
    bus_if.disp_ready = '0;
    bus_if.core_done  = '0;
    enq_data          = '0;
    heap_refresh();
    @(negedge CLK);
    test_reset();
    test_basic();
    test_all_busy();
    test_stall();
    test_enq_block();
    test_gvt();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
